// File: rtl/i2c_pkg.sv
// Shared constants and FSM encoding for the I2C register bridge.
package i2c_pkg;

  localparam int I2C_BYTE_W = 8;

  localparam logic [I2C_BYTE_W-1:0] BAD_PTR_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/i2c_event_detect.sv
// Registered rising-edge detector for the slave's rd_valid / wr_acked strobes.
module i2c_event_detect (
  input  logic clk,
  input  logic rst,
  input  logic rd_valid,
  input  logic wr_acked,
  output logic rd_evt,
  output logic wr_evt
);

  logic rd_valid_q;
  logic wr_acked_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      wr_acked_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid;
      wr_acked_q <= wr_acked;
    end
  end

  assign rd_evt = rd_valid & ~rd_valid_q;
  assign wr_evt = wr_acked & ~wr_acked_q;

endmodule

// File: rtl/i2c_reg_bridge.sv
// Pointer-addressed register file behind i2c_slave, shared with FPGA fabric
// through a synchronous read/write port.
module i2c_reg_bridge
  import i2c_pkg::*;
#(
  parameter int                  NUM_REGS = 16,
  parameter int                  ADDR_W   = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       slave_selected,
  input  logic [I2C_BYTE_W-1:0]      rd_data,
  input  logic                       rd_valid,
  input  logic                       wr_acked,
  output logic [I2C_BYTE_W-1:0]      wr_data,
  input  logic [ADDR_W-1:0]          fab_addr,
  input  logic                       fab_wr_en,
  input  logic [I2C_BYTE_W-1:0]      fab_wr_data,
  output logic [I2C_BYTE_W-1:0]      fab_rd_data,
  output logic [NUM_REGS*8-1:0]      regs_out,
  output logic                       i2c_wr_stb,
  output logic [ADDR_W-1:0]          i2c_wr_addr,
  output logic                       ptr_err,
  output logic                       fab_collide
);

  localparam logic [ADDR_W:0]     REGS_A   = (ADDR_W+1)'(NUM_REGS);
  localparam logic [I2C_BYTE_W:0] REGS_B   = (I2C_BYTE_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0]   LAST_IDX = ADDR_W'(NUM_REGS-1);

  logic [I2C_BYTE_W-1:0] regs [NUM_REGS];
  state_t                state, state_nxt;
  logic                  sel_q, sel_rise;
  logic                  rd_evt, wr_evt_raw, wr_evt;
  logic [ADDR_W-1:0]     ptr, ptr_inc_val;
  logic                  ptr_bad, ptr_ok, rd_bad, fab_ok;
  logic                  ptr_load, ptr_inc, commit;

  i2c_event_detect u_evt (
    .clk      (clk),
    .rst      (rst),
    .rd_valid (rd_valid),
    .wr_acked (wr_acked),
    .rd_evt   (rd_evt),
    .wr_evt   (wr_evt_raw)
  );

  // A simultaneous wr_acked event is a protocol violation; rd_valid wins.
  assign wr_evt      = wr_evt_raw & ~rd_evt;
  assign sel_rise    = slave_selected & ~sel_q;
  assign rd_bad      = {1'b0, rd_data} >= REGS_B;
  assign ptr_ok      = !ptr_bad && ({1'b0, ptr} < REGS_A);
  assign fab_ok      = {1'b0, fab_addr} < REGS_A;
  assign ptr_inc_val = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= 1'b0;
    end else begin
      state <= state_nxt;
      sel_q <= slave_selected;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!slave_selected) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (sel_rise) state_nxt = PTR;
        PTR:     if (rd_evt || wr_evt) state_nxt = DATA;
        DATA:    state_nxt = DATA;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ptr_load = 1'b0;
    ptr_inc  = 1'b0;
    commit   = 1'b0;
    case (state)
      PTR: begin
        if (rd_evt)      ptr_load = 1'b1;
        else if (wr_evt) ptr_inc  = 1'b1;
      end
      DATA: begin
        if (rd_evt) begin
          commit  = ptr_ok && !RO_MASK[ptr];
          ptr_inc = 1'b1;
        end else if (wr_evt) begin
          ptr_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      ptr_bad <= 1'b0;
      ptr_err <= 1'b0;
    end else if (ptr_load) begin
      ptr     <= rd_data[ADDR_W-1:0];
      ptr_bad <= rd_bad;
      ptr_err <= ptr_err | rd_bad;
    end else if (ptr_inc) begin
      ptr     <= ptr_inc_val;
    end
  end

  // I2C commits beat a fabric write to the same register; commits never
  // target read-only registers, so there the fabric write stands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && ptr == ADDR_W'(i))
          regs[i] <= rd_data;
        else if (fab_wr_en && fab_ok && fab_addr == ADDR_W'(i))
          regs[i] <= fab_wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_data     <= '0;
      fab_rd_data <= '0;
      i2c_wr_stb  <= 1'b0;
      i2c_wr_addr <= '0;
      fab_collide <= 1'b0;
    end else begin
      wr_data     <= ptr_ok ? regs[ptr] : BAD_PTR_DATA;
      fab_rd_data <= fab_ok ? regs[fab_addr] : '0;
      i2c_wr_stb  <= commit;
      if (commit) i2c_wr_addr <= ptr;
      fab_collide <= commit && fab_wr_en && fab_ok && (fab_addr == ptr);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_out[8*i +: 8] = regs[i];
  end

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Self-checking bench for i2c_reg_bridge against a transaction-level model.
module tb_i2c_reg_bridge;

  localparam int          NR = 16;
  localparam logic [15:0] RO = 16'h0081;

  logic         clk = 1'b0;
  logic         rst;
  logic         slave_selected;
  logic [7:0]   rd_data;
  logic         rd_valid;
  logic         wr_acked;
  logic [7:0]   wr_data;
  logic [3:0]   fab_addr;
  logic         fab_wr_en;
  logic [7:0]   fab_wr_data;
  logic [7:0]   fab_rd_data;
  logic [NR*8-1:0] regs_out;
  logic         i2c_wr_stb;
  logic [3:0]   i2c_wr_addr;
  logic         ptr_err;
  logic         fab_collide;

  always #5 clk = ~clk;

  i2c_reg_bridge #(.NUM_REGS(NR), .ADDR_W(4), .RO_MASK(RO)) dut (
    .clk(clk), .rst(rst), .slave_selected(slave_selected),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_acked(wr_acked),
    .wr_data(wr_data), .fab_addr(fab_addr), .fab_wr_en(fab_wr_en),
    .fab_wr_data(fab_wr_data), .fab_rd_data(fab_rd_data),
    .regs_out(regs_out), .i2c_wr_stb(i2c_wr_stb), .i2c_wr_addr(i2c_wr_addr),
    .ptr_err(ptr_err), .fab_collide(fab_collide)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register contents, pointer and flags as the host sees them.
  logic [7:0] m_regs [NR];
  int         m_ptr;
  bit         m_bad, m_err, m_first;
  int         exp_stb = 0, exp_col = 0, exp_last = 0;
  int         stb_cnt = 0, col_cnt = 0;
  logic [3:0] last_stb_addr = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (i2c_wr_stb) begin
        stb_cnt++;
        last_stb_addr = i2c_wr_addr;
      end
      if (fab_collide) col_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_ptr = 0; m_bad = 0; m_err = 0; m_first = 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sel();
    slave_selected = 1'b1; m_first = 1; tick(2);
  endtask

  task automatic desel();
    slave_selected = 1'b0; tick(2);
  endtask

  function automatic logic [7:0] dut_reg(input int i);
    return regs_out[8*i +: 8];
  endfunction

  task automatic send_fab(input logic [7:0] b, input bit fe, input int fa, input logic [7:0] fd);
    rd_data = b; rd_valid = 1'b1;
    fab_wr_en = fe; fab_addr = 4'(fa); fab_wr_data = fd;
    tick(1);
    fab_wr_en = 1'b0;
    tick($urandom_range(0, 2));
    rd_valid = 1'b0;
    tick(2);
    if (fe) m_regs[fa] = fd;
    if (m_first) begin
      m_first = 0;
      m_ptr = b % NR;
      m_bad = (b >= NR);
      if (m_bad) m_err = 1;
    end else begin
      if (!m_bad && !RO[m_ptr]) begin
        m_regs[m_ptr] = b; exp_stb++; exp_last = m_ptr;
        if (fe && fa == m_ptr) exp_col++;
      end
      m_ptr = (m_ptr + 1) % NR;
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_fab(b, 1'b0, 0, 8'h00);
  endtask

  task automatic ack();
    chk("wr_data", 32'(wr_data), 32'(m_bad ? 8'hFF : m_regs[m_ptr]));
    wr_acked = 1'b1;
    tick($urandom_range(1, 3));
    wr_acked = 1'b0;
    tick(2);
    m_first = 0;
    m_ptr = (m_ptr + 1) % NR;
  endtask

  task automatic fab_write(input int a, input logic [7:0] d);
    fab_addr = 4'(a); fab_wr_data = d; fab_wr_en = 1'b1;
    tick(1);
    fab_wr_en = 1'b0;
    tick(1);
    m_regs[a] = d;
  endtask

  task automatic check_all();
    for (int i = 0; i < NR; i++) chk($sformatf("reg%0d", i), 32'(dut_reg(i)), 32'(m_regs[i]));
    chk("ptr_err", 32'(ptr_err), 32'(m_err));
    chk("stb_cnt", stb_cnt, exp_stb);
    chk("col_cnt", col_cnt, exp_col);
  endtask

  initial begin
    logic [7:0] p;
    int kind, n, fa;
    bit fe;
    rst = 1'b1; slave_selected = 1'b0; rd_data = '0; rd_valid = 1'b0;
    wr_acked = 1'b0; fab_addr = '0; fab_wr_en = 1'b0; fab_wr_data = '0;
    m_reset();
    tick(3);
    chk("rst_regs", 32'(|regs_out), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_fab_rd", 32'(fab_rd_data), 0);
    chk("rst_flags", {29'd0, ptr_err, i2c_wr_stb, fab_collide}, 0);
    chk("rst_wr_addr", 32'(i2c_wr_addr), 0);
    rst = 1'b0;
    tick(1);

    // Write burst
    sel(); send(8'h03); send(8'hAA); send(8'hBB); desel();
    chk("burst_r3", 32'(dut_reg(3)), 32'hAA);
    chk("burst_r4", 32'(dut_reg(4)), 32'hBB);
    chk("burst_stb", stb_cnt, 2);
    chk("burst_addr", 32'(last_stb_addr), 4);

    // Pointer then read; ptr ends at 5
    fab_write(5, 8'h5C);
    sel(); send(8'h03); desel();
    sel(); ack(); chk("read_aa", 32'(m_regs[3]), 32'hAA); ack();
    chk("ptr5_data", 32'(wr_data), 32'h5C);
    desel();

    // Wrap and RO protection
    sel(); send(8'h0F); send(8'h11); send(8'h22); desel();
    chk("wrap_r15", 32'(dut_reg(15)), 32'h11);
    chk("wrap_r0", 32'(dut_reg(0)), 32'h00);
    chk("wrap_stb", stb_cnt, 3);

    // Bad pointer
    fab_write(2, 8'h3C);
    sel(); send(8'h20);
    chk("bad_err", 32'(ptr_err), 1);
    chk("bad_wr_data", 32'(wr_data), 32'hFF);
    send(8'h55); desel();
    chk("bad_stb", stb_cnt, 3);
    chk("bad_r1", 32'(dut_reg(1)), 32'(m_regs[1]));
    sel(); send(8'h02); desel();
    sel(); chk("good_data", 32'(wr_data), 32'h3C); ack(); desel();
    chk("err_sticky", 32'(ptr_err), 1);

    // Collisions: RW register, RO register, distinct registers
    sel(); send(8'h05); send_fab(8'hE1, 1'b1, 5, 8'h1F); desel();
    chk("col_r5", 32'(dut_reg(5)), 32'hE1);
    chk("col_cnt1", col_cnt, 1);
    sel(); send(8'h07); send_fab(8'h44, 1'b1, 7, 8'h9D); desel();
    chk("ro_r7", 32'(dut_reg(7)), 32'h9D);
    chk("col_cnt_ro", col_cnt, 1);
    sel(); send(8'h08); send_fab(8'h66, 1'b1, 9, 8'h77); desel();
    chk("split_r8", 32'(dut_reg(8)), 32'h66);
    chk("split_r9", 32'(dut_reg(9)), 32'h77);
    check_all();

    // Asynchronous reset between bytes
    sel(); send(8'h06); send(8'h77);
    #2 rst = 1'b1;
    #1;
    chk("arst_regs", 32'(|regs_out), 0);
    chk("arst_err", 32'(ptr_err), 0);
    chk("arst_wr_data", 32'(wr_data), 0);
    m_reset();
    slave_selected = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    fab_write(0, 8'h5A); fab_write(1, 8'h6B);
    sel(); ack(); ack(); desel();
    sel(); send(8'h01); send(8'h99); desel();
    chk("arst_ptr_state", 32'(dut_reg(1)), 32'h99);
    check_all();

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      sel();
      kind = $urandom_range(0, 2);
      if (kind != 1) begin
        p = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
        send(p);
      end
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        if (kind == 0) begin
          fe = 1'($urandom_range(0, 1));
          fa = $urandom_range(0, 1) ? m_ptr : $urandom_range(0, NR-1);
          send_fab(8'($urandom), fe, fa, 8'($urandom));
        end else begin
          ack();
        end
      end
      desel();
      if (t % 15 == 14) check_all();
    end

    for (int a = 0; a < NR; a++) begin
      fab_addr = 4'(a);
      tick(1);
      chk($sformatf("fab_rd%0d", a), 32'(fab_rd_data), 32'(m_regs[a]));
    end
    check_all();
    chk("last_addr", 32'(last_stb_addr), exp_last);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
